tmem_read_responder: RTL
========================

Name: tmem_read_responder

Overview:
- Serves texture-memory (TMEM) read requests issued by NUM_CORES execution units.
- Arbitrates round-robin among requesting cores and performs one read at a time on an external variable-latency memory port.
- Returns the row to the granted core with a one-cycle data-available pulse.
- Sits between the per-core TMEM request ports and the shared TMEM/SRAM controller.

Parameters:
- NUM_CORES, 4, number of requesting execution units (1..16).
- ADDR_WIDTH, 20, width of the memory-side address.
- DATA_WIDTH, 96, row width (three 32-bit channels X,Y,Z, X in the MSBs).
- TIMEOUT_CYCLES, 255, maximum cycles to wait for a memory acknowledge (1..1023).

Ports:
- Clock  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- iTMEMDataRequest  in  NUM_CORES  per-core level request; bit i belongs to core i.
- iTMEMReadAddress  in  NUM_CORES*DATA_WIDTH  per-core address rows; core i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- oTMEMReadData  out  DATA_WIDTH  returned row, broadcast to all cores.
- oTMEMDataAvailable  out  NUM_CORES  one-hot, one-cycle pulse marking oTMEMReadData valid for core i.
- oMemAddress  out  ADDR_WIDTH  memory read address.
- oMemReadEnable  out  1  memory read strobe; held until acknowledge or timeout.
- iMemData  in  DATA_WIDTH  memory read data; valid when iMemAck=1.
- iMemAck  in  1  memory acknowledge, single-cycle.
- oBusy  out  1  high in any state other than IDLE.
- oGrantIndex  out  4  index of the core currently or last served.
- oTimeoutError  out  1  sticky timeout flag.

Behaviour:
- Clock/reset: one clock; Reset is synchronous, active-high.
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, timeout counter 0, mask register 0.
- Reset mid-operation:
  - oMemReadEnable and oTMEMDataAvailable are 0 after the reset edge.
  - A late iMemAck is ignored.
  - A core still holding its request is served again after reset.
- Address extraction: memory address = bits [DATA_WIDTH-1 -: 32] (X channel) of the core's slice, truncated to the low ADDR_WIDTH bits.
- Request rule (core side):
  - A core holds request high and its address stable until it sees its available bit.
  - The core drops request on the cycle after the pulse.
- States:
  - IDLE:
    - Eligible = request & ~mask.
    - If eligible is non-zero, grant the first set bit at or after the pointer, wrapping modulo NUM_CORES.
    - Register the address, oMemReadEnable=1, oGrantIndex=grant, pointer=grant+1 (wrap), clear counter, go WAIT.
    - The mask clears every IDLE cycle.
  - WAIT:
    - oMemReadEnable stays 1 and the counter increments.
    - If iMemAck=1: latch iMemData, oMemReadEnable=0, go RESPOND.
    - Else if counter == TIMEOUT_CYCLES-1: latch data = 0, set oTimeoutError, oMemReadEnable=0, go RESPOND.
    - An ack arriving on the same cycle as timeout wins; data is kept and no error is raised.
  - RESPOND:
    - oTMEMDataAvailable[grant]=1 for exactly this cycle, with oTMEMReadData valid.
    - Set mask bit = grant so that core's not-yet-dropped request is ignored next cycle.
    - Go IDLE.
- oTMEMReadData holds its last value after the pulse; it is not cleared.
- Latency: request sampled at edge E, ack sampled at edge E+k (k≥1), pulse visible between edges E+k and E+k+1. Minimum request-to-pulse latency is 2 cycles.
- Throughput: a back-to-back request from a different core is granted in the IDLE cycle following RESPOND; the minimum period is 3 cycles per read.
- NUM_CORES=1: arbitration degenerates; the mask still applies.
- oTimeoutError clears only on Reset.

Test Plan:
- Single core, NUM_CORES=4: core 2 requests address X-channel 0x00000123, memory acks 3 cycles after the strobe with 0xAAAA…; expect oMemAddress=0x00123, oTMEMDataAvailable=4'b0100 for one cycle carrying the data, oGrantIndex=2.
- All four cores request continuously from reset: grant order 0,1,2,3,0…; each pulse exactly one cycle; the 3-cycle period is met with immediate acks.
- Core masking: core 1 keeps request high for one extra cycle after its pulse while no other core requests; expect no second read on that cycle, and a new grant to core 1 only on the following IDLE cycle.
- Timeout: with TIMEOUT_CYCLES=8 and no ack, expect oMemReadEnable high for exactly 8 cycles, a zero-data pulse, and oTimeoutError=1 sticky. Repeat with the ack on the 8th cycle: data returned and oTimeoutError stays 0.
- Reset mid-WAIT: assert Reset while oMemReadEnable=1, then an ack arrives next cycle; expect all outputs 0, the ack ignored, and the still-requesting core re-served starting from pointer 0 after reset.

Source files
------------

// File: rtl/tmem_read_responder.sv
// Round-robin TMEM read responder: arbitrates per-core row requests onto one
// variable-latency memory port and returns each row with a one-cycle pulse.
module tmem_read_responder #(
    parameter int NUM_CORES      = 4,
    parameter int ADDR_WIDTH     = 20,
    parameter int DATA_WIDTH     = 96,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            Clock,
    input  logic                            Reset,
    input  logic [NUM_CORES-1:0]            iTMEMDataRequest,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] iTMEMReadAddress,
    output logic [DATA_WIDTH-1:0]           oTMEMReadData,
    output logic [NUM_CORES-1:0]            oTMEMDataAvailable,
    output logic [ADDR_WIDTH-1:0]           oMemAddress,
    output logic                            oMemReadEnable,
    input  logic [DATA_WIDTH-1:0]           iMemData,
    input  logic                            iMemAck,
    output logic                            oBusy,
    output logic [3:0]                      oGrantIndex,
    output logic                            oTimeoutError
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESPOND
    } state_t;

    localparam int               CNT_W        = 10;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                r_state;
    logic [3:0]            r_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [NUM_CORES-1:0]  r_mask;
    logic [DATA_WIDTH-1:0] r_read_data;
    logic [NUM_CORES-1:0]  r_avail;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_mem_re;
    logic [3:0]            r_grant;
    logic                  r_timeout_err;

    logic [NUM_CORES-1:0]  w_eligible;
    logic                  w_found;
    logic [3:0]            w_grant;
    logic [3:0]            w_next_ptr;
    logic [31:0]           w_x_channel;
    logic [NUM_CORES-1:0]  w_grant_onehot;
    logic                  w_unused;

    // Two passes give "first set bit at or after the pointer, wrapping".
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_eligible     = iTMEMDataRequest & ~r_mask;
        w_found        = 1'b0;
        w_grant        = '0;
        w_x_channel    = '0;
        w_grant_onehot = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!w_found && w_eligible[i] && (4'(i) >= r_ptr)) begin
                w_found = 1'b1;
                w_grant = 4'(i);
            end
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            if (!w_found && w_eligible[i]) begin
                w_found = 1'b1;
                w_grant = 4'(i);
            end
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            if (w_grant == 4'(i)) begin
                w_x_channel = iTMEMReadAddress[i*DATA_WIDTH + DATA_WIDTH - 32 +: 32];
            end
            w_grant_onehot[i] = (r_grant == 4'(i));
        end
    end

    assign w_next_ptr = (w_grant == 4'(NUM_CORES - 1)) ? 4'd0 : w_grant + 4'd1;

    // Y/Z channels and the high X bits are carried but not needed for the address.
    assign w_unused = ^{iTMEMReadAddress, w_x_channel};

    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments only, reset included.
        if (Reset) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_count       <= '0;
            r_mask        <= '0;
            r_read_data   <= '0;
            r_avail       <= '0;
            r_mem_addr    <= '0;
            r_mem_re      <= 1'b0;
            r_grant       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_avail <= '0;
            case (r_state)
                S_IDLE: begin
                    r_mask <= '0;
                    if (w_found) begin
                        r_mem_addr <= w_x_channel[ADDR_WIDTH-1:0];
                        r_mem_re   <= 1'b1;
                        r_grant    <= w_grant;
                        r_ptr      <= w_next_ptr;
                        r_count    <= '0;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_count <= r_count + 1'b1;
                    // An ack on the final cycle beats the timeout.
                    if (iMemAck) begin
                        r_read_data <= iMemData;
                        r_mem_re    <= 1'b0;
                        r_avail     <= w_grant_onehot;
                        r_state     <= S_RESPOND;
                    end else if (r_count == TIMEOUT_LAST) begin
                        r_read_data   <= '0;
                        r_timeout_err <= 1'b1;
                        r_mem_re      <= 1'b0;
                        r_avail       <= w_grant_onehot;
                        r_state       <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    // Hide the served core's request for the one cycle it takes to drop it.
                    r_mask  <= w_grant_onehot;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign oTMEMReadData      = r_read_data;
    assign oTMEMDataAvailable = r_avail;
    assign oMemAddress        = r_mem_addr;
    assign oMemReadEnable     = r_mem_re;
    assign oBusy              = (r_state != S_IDLE);
    assign oGrantIndex        = r_grant;
    assign oTimeoutError      = r_timeout_err;

endmodule
